// File: rtl/du_dump_sequencer.sv
// Debug-unit dump sequencer: streams PC, x0..x31 and a DMEM window over the UART, LSB first.
// Optional DUMP_CHECKSUM_EN appends one XOR byte over everything sent before DONE.
module du_dump_sequencer #(
    parameter int unsigned NB_PC           = 32,
    parameter int unsigned NB_REG          = 32,
    parameter int unsigned NB_DATA         = 32,
    parameter int unsigned NB_UART_DATA    = 8,
    parameter int unsigned NB_REGFILE_ADDR = 5,
    parameter int unsigned DMEM_ADDR_WIDTH = 10,
    parameter int unsigned RD_LAT          = 2
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [DMEM_ADDR_WIDTH-1:0] i_dmem_base,
    input  logic [DMEM_ADDR_WIDTH-1:0] i_dmem_words,
    input  logic [NB_PC-1:0]           i_pc,
    input  logic [NB_REG-1:0]          i_regfile_data,
    input  logic [NB_DATA-1:0]         i_dmem_data,
    input  logic                       i_tx_done,
    output logic                       o_regfile_rd,
    output logic [NB_REGFILE_ADDR-1:0] o_regfile_raddr,
    output logic                       o_dmem_ren,
    output logic [DMEM_ADDR_WIDTH-1:0] o_dmem_raddr,
    output logic [1:0]                 o_dmem_rsize,
    output logic                       o_tx_start,
    output logic [NB_UART_DATA-1:0]    o_tx_data,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int unsigned NB_ITEM    = 32;
    localparam int unsigned ITEM_BYTES = NB_ITEM / NB_UART_DATA;
    localparam int unsigned NB_WAIT    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [2:0]                 LAST_BYTE = 3'(ITEM_BYTES - 1);
    localparam logic [NB_WAIT-1:0]         WAIT_LAST = NB_WAIT'(RD_LAT - 1);
    localparam logic [DMEM_ADDR_WIDTH-1:0] ADDR_STEP = DMEM_ADDR_WIDTH'(4);
    localparam logic [DMEM_ADDR_WIDTH-1:0] ONE_WORD  = DMEM_ADDR_WIDTH'(1);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [3:0] {
        StIdle, StLoadPc, StReq, StWait, StTxStart, StTxWait, StNext, StCksum, StDone
    } state_e;
    typedef enum logic [1:0] {PhPc, PhReg, PhDmem, PhCksum} phase_e;
    localparam state_e StFinish = StCksum;
`else
    typedef enum logic [3:0] {
        StIdle, StLoadPc, StReq, StWait, StTxStart, StTxWait, StNext, StDone
    } state_e;
    typedef enum logic [1:0] {PhPc, PhReg, PhDmem} phase_e;
    localparam state_e StFinish = StDone;
`endif

    state_e                       state_q, state_d;
    phase_e                       phase_q, phase_d;
    logic [NB_ITEM-1:0]           shift_q, shift_d;
    logic [2:0]                   byte_cnt_q, byte_cnt_d;
    logic [NB_WAIT-1:0]           wait_cnt_q, wait_cnt_d;
    logic [NB_REGFILE_ADDR-1:0]   reg_idx_q, reg_idx_d;
    logic [DMEM_ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [DMEM_ADDR_WIDTH-1:0]   words_q, words_d;
    logic [NB_PC-1:0]             pc_lat_q, pc_lat_d;
`ifdef DUMP_CHECKSUM_EN
    logic [NB_UART_DATA-1:0]      cksum_q, cksum_d;
`endif

    logic                         regfile_rd_d;
    logic [NB_REGFILE_ADDR-1:0]   regfile_raddr_d;
    logic                         dmem_ren_d;
    logic [DMEM_ADDR_WIDTH-1:0]   dmem_raddr_d;
    logic [1:0]                   dmem_rsize_d;
    logic                         tx_start_d;
    logic [NB_UART_DATA-1:0]      tx_data_d;
    logic                         busy_d;
    logic                         done_d;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        wait_cnt_d = wait_cnt_q;
        reg_idx_d  = reg_idx_q;
        cur_addr_d = cur_addr_q;
        words_d    = words_q;
        pc_lat_d   = pc_lat_q;
`ifdef DUMP_CHECKSUM_EN
        cksum_d    = cksum_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    pc_lat_d   = i_pc;
                    cur_addr_d = i_dmem_base;
                    words_d    = i_dmem_words;
                    state_d    = StLoadPc;
                end
            end
            StLoadPc: begin
                shift_d    = NB_ITEM'(pc_lat_q);
                byte_cnt_d = '0;
                phase_d    = PhPc;
`ifdef DUMP_CHECKSUM_EN
                cksum_d    = '0;
`endif
                state_d    = StTxStart;
            end
            StReq: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                // Read data is only valid on the last of the RD_LAT wait cycles.
                if (wait_cnt_q == WAIT_LAST) begin
                    shift_d    = (phase_q == PhReg) ? NB_ITEM'(i_regfile_data)
                                                    : NB_ITEM'(i_dmem_data);
                    byte_cnt_d = '0;
                    state_d    = StTxStart;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StTxStart: begin
`ifdef DUMP_CHECKSUM_EN
                cksum_d = cksum_q ^ shift_q[NB_UART_DATA-1:0];
`endif
                state_d = StTxWait;
            end
            StTxWait: begin
                if (i_tx_done) begin
                    shift_d    = shift_q >> NB_UART_DATA;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    state_d    = (byte_cnt_q == LAST_BYTE) ? StNext : StTxStart;
                end
            end
            StNext: begin
                state_d = StReq;
                unique case (phase_q)
                    PhPc: begin
                        phase_d   = PhReg;
                        reg_idx_d = '0;
                    end
                    PhReg: begin
                        if (&reg_idx_q) begin
                            if (words_q != '0) begin
                                phase_d = PhDmem;
                            end else begin
                                state_d = StFinish;
                            end
                        end else begin
                            reg_idx_d = reg_idx_q + 1'b1;
                        end
                    end
                    PhDmem: begin
                        cur_addr_d = cur_addr_q + ADDR_STEP;
                        words_d    = words_q - ONE_WORD;
                        if (words_q == ONE_WORD) begin
                            state_d = StFinish;
                        end
                    end
`ifdef DUMP_CHECKSUM_EN
                    PhCksum: state_d = StDone;
`endif
                    default: state_d = StIdle;
                endcase
            end
`ifdef DUMP_CHECKSUM_EN
            StCksum: begin
                // Single-byte item: start the byte counter at its last slot.
                shift_d    = NB_ITEM'(cksum_q);
                byte_cnt_d = LAST_BYTE;
                phase_d    = PhCksum;
                state_d    = StTxStart;
            end
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (i_abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    // Outputs are registered copies of what the next state presents.
    always_comb begin
        regfile_rd_d    = (state_d == StReq) && (phase_d == PhReg);
        dmem_ren_d      = (state_d == StReq) && (phase_d == PhDmem);
        regfile_raddr_d = regfile_rd_d ? reg_idx_d : '0;
        dmem_raddr_d    = dmem_ren_d ? cur_addr_d : '0;
        dmem_rsize_d    = dmem_ren_d ? 2'b10 : 2'b00;
        tx_start_d      = (state_d == StTxStart);
        busy_d          = (state_d != StIdle);
        done_d          = (state_d == StDone);
        tx_data_d       = o_tx_data;
        if (tx_start_d) begin
            tx_data_d = shift_d[NB_UART_DATA-1:0];
        end else if (state_d == StIdle) begin
            tx_data_d = '0;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= StIdle;
            phase_q         <= PhPc;
            shift_q         <= '0;
            byte_cnt_q      <= '0;
            wait_cnt_q      <= '0;
            reg_idx_q       <= '0;
            cur_addr_q      <= '0;
            words_q         <= '0;
            pc_lat_q        <= '0;
`ifdef DUMP_CHECKSUM_EN
            cksum_q         <= '0;
`endif
            o_regfile_rd    <= 1'b0;
            o_regfile_raddr <= '0;
            o_dmem_ren      <= 1'b0;
            o_dmem_raddr    <= '0;
            o_dmem_rsize    <= 2'b00;
            o_tx_start      <= 1'b0;
            o_tx_data       <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            shift_q         <= shift_d;
            byte_cnt_q      <= byte_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            reg_idx_q       <= reg_idx_d;
            cur_addr_q      <= cur_addr_d;
            words_q         <= words_d;
            pc_lat_q        <= pc_lat_d;
`ifdef DUMP_CHECKSUM_EN
            cksum_q         <= cksum_d;
`endif
            o_regfile_rd    <= regfile_rd_d;
            o_regfile_raddr <= regfile_raddr_d;
            o_dmem_ren      <= dmem_ren_d;
            o_dmem_raddr    <= dmem_raddr_d;
            o_dmem_rsize    <= dmem_rsize_d;
            o_tx_start      <= tx_start_d;
            o_tx_data       <= tx_data_d;
            o_busy          <= busy_d;
            o_done          <= done_d;
        end
    end

endmodule

// File: tb/tb_du_dump_sequencer.sv
// Scoreboard bench for du_dump_sequencer: expected byte/read streams come from a dump model,
// a monitor pops and compares them as the DUT emits UART starts and read requests.
`timescale 1ns/1ps
module tb_du_dump_sequencer;

    localparam int unsigned AW     = 10;
    localparam int unsigned RD_LAT = 2;
    localparam int          BUDGET = 20000;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_cmd, stray_start, start;
    logic           abort;
    logic [AW-1:0]  dmem_base, dmem_words;
    logic [31:0]    pc, regfile_data, dmem_data;
    logic           resp_done, stray_done, tx_done;
    logic           regfile_rd;
    logic [4:0]     regfile_raddr;
    logic           dmem_ren;
    logic [AW-1:0]  dmem_raddr;
    logic [1:0]     dmem_rsize;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           busy, done;

    assign start   = start_cmd | stray_start;
    assign tx_done = resp_done | stray_done;

    du_dump_sequencer #(
        .NB_PC(32), .NB_REG(32), .NB_DATA(32), .NB_UART_DATA(8),
        .NB_REGFILE_ADDR(5), .DMEM_ADDR_WIDTH(AW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_dmem_base(dmem_base), .i_dmem_words(dmem_words), .i_pc(pc),
        .i_regfile_data(regfile_data), .i_dmem_data(dmem_data), .i_tx_done(tx_done),
        .o_regfile_rd(regfile_rd), .o_regfile_raddr(regfile_raddr),
        .o_dmem_ren(dmem_ren), .o_dmem_raddr(dmem_raddr), .o_dmem_rsize(dmem_rsize),
        .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]   regs [32];
    logic [31:0]   dmem [256];
    logic [7:0]    exp_bytes [$];
    logic [4:0]    exp_raddr [$];
    logic [AW-1:0] exp_daddr [$];
    bit            done_armed = 1'b0;
    int            done_seen = 0;
    bit            stray_en = 1'b0;
    logic [7:0]    held;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void fail_now(string name, string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endfunction

    // Reference dump: items PC, x0..x31, DMEM words (address wraps mod 2^AW), 4 bytes LSB first.
    function automatic void build_expected(logic [31:0] p, logic [AW-1:0] base, logic [AW-1:0] nw);
        logic [31:0]   items [$];
        logic [AW-1:0] a;
        logic [31:0]   w;
        logic [7:0]    x;
        x = 8'h00;
        items.push_back(p);
        for (int r = 0; r < 32; r++) begin
            items.push_back(regs[r]);
            exp_raddr.push_back(5'(r));
        end
        for (int i = 0; i < int'(nw); i++) begin
            a = base + AW'(4 * i);
            exp_daddr.push_back(a);
            items.push_back(dmem[a[AW-1:2]]);
        end
        foreach (items[k]) begin
            w = items[k];
            for (int b = 0; b < 4; b++) begin
                exp_bytes.push_back(w[8*b +: 8]);
                x ^= w[8*b +: 8];
            end
        end
`ifdef DUMP_CHECKSUM_EN
        exp_bytes.push_back(x);
`endif
    endfunction

    // Read-port model: data for a request shows up RD_LAT cycles later, noise otherwise.
    logic          rf_v0, rf_v1, rf_v2, dm_v0, dm_v1, dm_v2;
    logic [4:0]    rf_a0, rf_a1, rf_a2;
    logic [AW-1:0] dm_a0, dm_a1, dm_a2;
    initial begin
        {rf_v0, rf_v1, rf_v2, dm_v0, dm_v1, dm_v2} = '0;
        {rf_a0, rf_a1, rf_a2} = '0;
        {dm_a0, dm_a1, dm_a2} = '0;
        regfile_data = '0;
        dmem_data = '0;
        forever begin
            @(negedge clk);
            rf_v2 = rf_v1; rf_a2 = rf_a1; rf_v1 = rf_v0; rf_a1 = rf_a0;
            rf_v0 = regfile_rd; rf_a0 = regfile_raddr;
            dm_v2 = dm_v1; dm_a2 = dm_a1; dm_v1 = dm_v0; dm_a1 = dm_a0;
            dm_v0 = dmem_ren; dm_a0 = dmem_raddr;
            regfile_data = rf_v2 ? regs[rf_a2] : $urandom();
            dmem_data    = dm_v2 ? dmem[dm_a2[AW-1:2]] : $urandom();
        end
    end

    // UART model: done pulse 1..4 cycles after each start; data must hold meanwhile.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (tx_start) begin
                held = tx_data;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                if (busy) begin
                    check("tx_data_hold", {24'h0, tx_data}, {24'h0, held});
                    resp_done = 1'b1;
                end
            end
        end
    end

    // Disturbances that must be ignored: start while busy, tx_done while a read is requested.
    initial begin
        stray_done = 1'b0;
        stray_start = 1'b0;
        forever begin
            @(negedge clk);
            stray_done  = stray_en && (regfile_rd || dmem_ren);
            stray_start = stray_en && busy && ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                if (exp_bytes.size() == 0) fail_now("tx_byte", $sformatf("unexpected byte 0x%02h", tx_data));
                else check("tx_byte", {24'h0, tx_data}, {24'h0, exp_bytes.pop_front()});
            end
            if (regfile_rd) begin
                if (exp_raddr.size() == 0) fail_now("rf_raddr", $sformatf("unexpected read %0d", regfile_raddr));
                else check("rf_raddr", {27'h0, regfile_raddr}, {27'h0, exp_raddr.pop_front()});
            end
            if (dmem_ren) begin
                check("dmem_rsize", {30'h0, dmem_rsize}, 32'h2);
                if (exp_daddr.size() == 0) fail_now("dmem_raddr", $sformatf("unexpected read 0x%0h", dmem_raddr));
                else check("dmem_raddr", {22'h0, dmem_raddr}, {22'h0, exp_daddr.pop_front()});
            end
            if (done) begin
                done_seen++;
                if (!done_armed) fail_now("done", "o_done without a completed dump");
                else check("done_bytes_left", exp_bytes.size() + exp_raddr.size() + exp_daddr.size(), 0);
                done_armed = 1'b0;
            end
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, "_tx_start"}, {31'h0, tx_start}, 0);
        check({tag, "_tx_data"}, {24'h0, tx_data}, 0);
        check({tag, "_busy"}, {31'h0, busy}, 0);
        check({tag, "_done"}, {31'h0, done}, 0);
        check({tag, "_reads"}, {29'h0, regfile_rd, dmem_ren, 1'b0} | {27'h0, regfile_raddr}, 0);
        check({tag, "_dmem_addr"}, {20'h0, dmem_raddr, dmem_rsize}, 0);
    endtask

    task automatic flush_expected();
        exp_bytes.delete();
        exp_raddr.delete();
        exp_daddr.delete();
        done_armed = 1'b0;
    endtask

    // Start pulse at cycle N; first byte must appear at N+2. Inputs are scrambled after the latch.
    task automatic issue_start(logic [31:0] p, logic [AW-1:0] base, logic [AW-1:0] nw);
        build_expected(p, base, nw);
        done_armed = 1'b1;
        @(negedge clk);
        pc = p; dmem_base = base; dmem_words = nw;
        start_cmd = 1'b1;
        @(negedge clk);
        start_cmd = 1'b0;
        pc = $urandom(); dmem_base = AW'($urandom()); dmem_words = AW'($urandom());
        check("latency_n1_tx_start", {31'h0, tx_start}, 0);
        check("latency_n1_busy", {31'h0, busy}, 1);
        @(negedge clk);
        check("latency_n2_tx_start", {31'h0, tx_start}, 1);
    endtask

    task automatic wait_done();
        int d0;
        int cyc;
        d0 = done_seen;
        cyc = 0;
        while (done_seen == d0 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        if (done_seen == d0) fail_now("done_timeout", "no o_done within budget");
        @(negedge clk);
        check("busy_after_done", {31'h0, busy}, 0);
        check("done_one_cycle", {31'h0, done}, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic watch_quiet(int n);
        repeat (n) @(negedge clk);
        check("quiet_busy", {31'h0, busy}, 0);
    endtask

    initial begin
        int cnt;
        int cyc;
        rst = 1'b1; start_cmd = 1'b0; abort = 1'b0;
        pc = '0; dmem_base = '0; dmem_words = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i);
        for (int i = 0; i < 256; i++) dmem[i] = $urandom();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // PC + registers only.
        issue_start(32'h1234_5678, AW'(0), AW'(0));
        wait_done();

        // Two DMEM words after the registers.
        dmem[2] = 32'hDEAD_BEEF;
        dmem[3] = 32'hCAFE_F00D;
        issue_start(32'h1234_5678, AW'('h008), AW'(2));
        wait_done();

        // DMEM address wraps from the top of the space back to 0.
        issue_start($urandom(), AW'('h3FC), AW'(2));
        wait_done();

        // Abort in TX_WAIT of register 5 (25th byte), then a clean restart.
        issue_start(32'h1234_5678, AW'(0), AW'(0));
        cnt = 1;
        cyc = 0;
        while (cnt < 25 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (tx_start) cnt++;
        end
        if (cnt < 25) fail_now("abort_setup", "byte 25 never started");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {31'h0, busy}, 0);
        check("abort_tx_start", {31'h0, tx_start}, 0);
        check("abort_bytes_left", exp_bytes.size(), 132 - 25
`ifdef DUMP_CHECKSUM_EN
              + 1
`endif
        );
        flush_expected();
        watch_quiet(40);
        issue_start(32'h1234_5678, AW'(0), AW'(0));
        wait_done();

        // Ignored stray start and tx_done during a dump.
        stray_en = 1'b1;
        issue_start(32'h1234_5678, AW'(0), AW'(0));
        wait_done();
        issue_start($urandom(), AW'({$urandom_range(0, 255), 2'b00}), AW'(3));
        wait_done();
        stray_en = 1'b0;

        // Asynchronous reset mid-dump.
        issue_start($urandom(), AW'(0), AW'(4));
        repeat (300) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        flush_expected();
        watch_quiet(40);

        // Randomized dumps.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom();
            issue_start($urandom(), AW'({$urandom_range(0, 255), 2'b00}),
                        AW'($urandom_range(0, 6)));
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
